// File: rtl/ysyx_22050550_wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050550_wb_commit
// Purpose  : Writeback/commit stage. Arbitrates EXU/LSU results, writes the
//            register file, clears scoreboard busy bits, and counts retirements.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22050550_wb_commit #(
  parameter int DATA_W     = 64,
  parameter int PC_W       = 64,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 64
) (
  input  logic              clock,
  input  logic              reset,
  // EXU result channel
  input  logic              io_EXU_valid,
  output logic              io_EXU_ready,
  input  logic [4:0]        io_EXU_rd,
  input  logic              io_EXU_wen,
  input  logic [DATA_W-1:0] io_EXU_data,
  input  logic [PC_W-1:0]   io_EXU_pc,
  // LSU result channel
  input  logic              io_LSU_valid,
  output logic              io_LSU_ready,
  input  logic [4:0]        io_LSU_rd,
  input  logic              io_LSU_wen,
  input  logic [DATA_W-1:0] io_LSU_data,
  input  logic [PC_W-1:0]   io_LSU_pc,
  // Register file write port
  output logic              io_RF_wen,
  output logic [4:0]        io_RF_waddr,
  output logic [DATA_W-1:0] io_RF_wdata,
  // Scoreboard busy-clear
  output logic              io_WBU_wen,
  output logic [4:0]        io_WBU_waddr,
  // Retirement
  output logic              io_commit_valid,
  output logic [PC_W-1:0]   io_commit_pc,
  output logic [CNT_W-1:0]  io_instret
);

  localparam int         c_STARVE_W   = 4;
  localparam logic [3:0] c_STARVE_TOP = c_STARVE_W'(STARVE_MAX);

  logic [c_STARVE_W-1:0] r_starve;
  logic                  r_stage_valid;
  logic [4:0]            r_rd;
  logic                  r_wen;
  logic [DATA_W-1:0]     r_data;
  logic [PC_W-1:0]       r_pc;
  logic [CNT_W-1:0]      r_instret;

  logic w_starved;
  logic w_exu_fire;
  logic w_lsu_fire;
  logic w_commit;
  logic w_write;

  // Readies never look at their own producer's valid; with both valid they
  // are mutually exclusive, so at most one transfer happens per cycle.
  assign w_starved    = (r_starve == c_STARVE_TOP);
  assign io_EXU_ready = reset && (!io_LSU_valid || w_starved);
  assign io_LSU_ready = reset && !(io_EXU_valid && w_starved);

  assign w_exu_fire = io_EXU_valid && io_EXU_ready;
  assign w_lsu_fire = io_LSU_valid && io_LSU_ready;

  // A stage caught by reset is discarded without a commit pulse.
  assign w_commit = r_stage_valid && reset;
  assign w_write  = w_commit && r_wen && (r_rd != 5'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_starve      <= '0;
      r_stage_valid <= 1'b0;
      r_rd          <= '0;
      r_wen         <= 1'b0;
      r_data        <= '0;
      r_pc          <= '0;
      r_instret     <= '0;
    end else begin
      if (w_commit) begin
        r_instret <= r_instret + CNT_W'(1);
      end

      if (w_exu_fire) begin
        r_stage_valid <= 1'b1;
        r_rd          <= io_EXU_rd;
        r_wen         <= io_EXU_wen;
        r_data        <= io_EXU_data;
        r_pc          <= io_EXU_pc;
      end else if (w_lsu_fire) begin
        r_stage_valid <= 1'b1;
        r_rd          <= io_LSU_rd;
        r_wen         <= io_LSU_wen;
        r_data        <= io_LSU_data;
        r_pc          <= io_LSU_pc;
      end else begin
        r_stage_valid <= 1'b0;
      end

      if (w_exu_fire) begin
        r_starve <= '0;
      end else if (io_EXU_valid && !w_starved) begin
        r_starve <= r_starve + c_STARVE_W'(1);
      end
    end
  end

  assign io_commit_valid = w_commit;
  assign io_commit_pc    = r_pc;
  assign io_RF_wen       = w_write;
  assign io_RF_waddr     = r_rd;
  assign io_RF_wdata     = r_data;
  assign io_WBU_wen      = w_write;
  assign io_WBU_waddr    = r_rd;
  assign io_instret      = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050550_wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050550_wb_commit
// Purpose  : Randomized and directed bench for the writeback/commit stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050550_wb_commit;
  localparam int DW   = 64;
  localparam int PW   = 64;
  localparam int SMAX = 3;
  localparam int CW   = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          io_EXU_valid = 1'b0, io_EXU_ready, io_EXU_wen = 1'b0;
  logic [4:0]    io_EXU_rd = '0;
  logic [DW-1:0] io_EXU_data = '0;
  logic [PW-1:0] io_EXU_pc = '0;
  logic          io_LSU_valid = 1'b0, io_LSU_ready, io_LSU_wen = 1'b0;
  logic [4:0]    io_LSU_rd = '0;
  logic [DW-1:0] io_LSU_data = '0;
  logic [PW-1:0] io_LSU_pc = '0;
  logic          io_RF_wen, io_WBU_wen, io_commit_valid;
  logic [4:0]    io_RF_waddr, io_WBU_waddr;
  logic [DW-1:0] io_RF_wdata;
  logic [PW-1:0] io_commit_pc;
  logic [CW-1:0] io_instret;

  ysyx_22050550_wb_commit #(.DATA_W(DW), .PC_W(PW), .STARVE_MAX(SMAX), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .io_EXU_valid(io_EXU_valid), .io_EXU_ready(io_EXU_ready), .io_EXU_rd(io_EXU_rd),
    .io_EXU_wen(io_EXU_wen), .io_EXU_data(io_EXU_data), .io_EXU_pc(io_EXU_pc),
    .io_LSU_valid(io_LSU_valid), .io_LSU_ready(io_LSU_ready), .io_LSU_rd(io_LSU_rd),
    .io_LSU_wen(io_LSU_wen), .io_LSU_data(io_LSU_data), .io_LSU_pc(io_LSU_pc),
    .io_RF_wen(io_RF_wen), .io_RF_waddr(io_RF_waddr), .io_RF_wdata(io_RF_wdata),
    .io_WBU_wen(io_WBU_wen), .io_WBU_waddr(io_WBU_waddr),
    .io_commit_valid(io_commit_valid), .io_commit_pc(io_commit_pc), .io_instret(io_instret)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: the instruction accepted last cycle, retire count, and
  // how many consecutive cycles EXU has been passed over.
  logic          m_sv = 1'b0;
  logic [4:0]    m_rd = '0;
  logic          m_wen = 1'b0;
  logic [63:0]   m_data = '0, m_pc = '0, m_instret = '0;
  int            m_starve = 0;
  bit            m_exu_fire = 0, m_lsu_fire = 0;
  bit            cmp_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // EXU would win this cycle if it were valid: LSU idle, or EXU starved.
  function automatic bit exu_slot(input bit lsu_v, input int starve);
    return !lsu_v || (starve == SMAX);
  endfunction

  always @(negedge clock) begin
    logic ec, ew;
    if (cmp_en) begin
      ec = m_sv && (reset === 1'b1);
      ew = ec && m_wen && (m_rd != 5'd0);
      check("commit_valid", io_commit_valid, ec);
      check("rf_wen", io_RF_wen, ew);
      check("wbu_wen", io_WBU_wen, ew);
      check("rf_waddr", io_RF_waddr, m_rd);
      check("wbu_waddr", io_WBU_waddr, m_rd);
      check("rf_wdata", io_RF_wdata, m_data);
      check("commit_pc", io_commit_pc, m_pc);
      check("instret", io_instret, m_instret);
      check("exu_ready", io_EXU_ready, reset && exu_slot(io_LSU_valid, m_starve));
      check("lsu_ready", io_LSU_ready, reset && !(io_EXU_valid && m_starve == SMAX));
    end
  end

  task automatic tick();
    bit rs, ev, lv, ef, lf;
    logic [4:0] erd, lrd;
    logic ew, lw;
    logic [63:0] ed, ep, ld, lp;
    rs = reset; ev = io_EXU_valid; lv = io_LSU_valid;
    erd = io_EXU_rd; ew = io_EXU_wen; ed = io_EXU_data; ep = io_EXU_pc;
    lrd = io_LSU_rd; lw = io_LSU_wen; ld = io_LSU_data; lp = io_LSU_pc;
    ef = rs && ev && exu_slot(lv, m_starve);
    lf = rs && lv && !ef;
    @(posedge clock);
    if (!rs) begin
      m_sv = 0; m_rd = '0; m_wen = 0; m_data = '0; m_pc = '0; m_instret = '0; m_starve = 0;
    end else begin
      if (m_sv) m_instret = m_instret + 64'd1;
      if (ef) begin
        m_sv = 1; m_rd = erd; m_wen = ew; m_data = ed; m_pc = ep;
      end else if (lf) begin
        m_sv = 1; m_rd = lrd; m_wen = lw; m_data = ld; m_pc = lp;
      end else begin
        m_sv = 0;
      end
      if (ef) m_starve = 0;
      else if (ev) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
    end
    m_exu_fire = ef; m_lsu_fire = lf;
    #1;
  endtask

  task automatic set_exu(input bit v, input logic [4:0] rd, input bit w, input logic [63:0] d, input logic [63:0] p);
    io_EXU_valid = v; io_EXU_rd = rd; io_EXU_wen = w; io_EXU_data = d; io_EXU_pc = p;
  endtask

  task automatic set_lsu(input bit v, input logic [4:0] rd, input bit w, input logic [63:0] d, input logic [63:0] p);
    io_LSU_valid = v; io_LSU_rd = rd; io_LSU_wen = w; io_LSU_data = d; io_LSU_pc = p;
  endtask

  task automatic rand_exu();
    set_exu($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic rand_lsu();
    set_lsu($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_exu(0, '0, 0, '0, '0);
    set_lsu(0, '0, 0, '0, '0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset held with both producers valid
    reset = 1'b0;
    set_exu(1, 5'd3, 1, 64'h11, 64'h100);
    set_lsu(1, 5'd4, 1, 64'h22, 64'h200);
    tick();
    cmp_en = 1;
    tick();
    check("rst_exu_ready", io_EXU_ready, 0);
    check("rst_lsu_ready", io_LSU_ready, 0);
    check("rst_commit", io_commit_valid, 0);
    check("rst_rf_wen", io_RF_wen, 0);
    check("rst_instret", io_instret, 0);
    reset = 1'b1;
    #1;
    check("rel_lsu_ready", io_LSU_ready, 1);
    check("rel_exu_ready", io_EXU_ready, 0);
    tick();
    io_LSU_valid = 0;
    check("rel_first_commit", io_commit_valid, 1);
    check("rel_first_waddr", io_RF_waddr, 4);

    // EXU-only commit
    do_reset();
    set_exu(1, 5'd5, 1, 64'hDEAD, 64'h8000_0000);
    #1;
    check("exu_ready_same_cycle", io_EXU_ready, 1);
    tick();
    io_EXU_valid = 0;
    check("exu_rf_wen", io_RF_wen, 1);
    check("exu_wbu_wen", io_WBU_wen, 1);
    check("exu_waddr", io_RF_waddr, 5);
    check("exu_wdata", io_RF_wdata, 64'hDEAD);
    check("exu_pc", io_commit_pc, 64'h8000_0000);
    check("exu_instret_before", io_instret, 0);
    tick();
    check("exu_instret_after", io_instret, 1);
    check("exu_idle_commit", io_commit_valid, 0);

    // Contention: LSU,LSU,LSU,EXU repeating
    do_reset();
    rand_exu(); io_EXU_valid = 1;
    rand_lsu(); io_LSU_valid = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("cont_exu_ready", io_EXU_ready, (k % 4) == 3);
      check("cont_lsu_ready", io_LSU_ready, (k % 4) != 3);
      tick();
      if (m_exu_fire) begin rand_exu(); io_EXU_valid = 1; end
      if (m_lsu_fire) begin rand_lsu(); io_LSU_valid = 1; end
    end

    // x0 destination commits without a write
    do_reset();
    set_lsu(1, 5'd0, 1, 64'h1234, 64'h8000_0040);
    tick();
    io_LSU_valid = 0;
    check("x0_commit", io_commit_valid, 1);
    check("x0_rf_wen", io_RF_wen, 0);
    check("x0_wbu_wen", io_WBU_wen, 0);
    tick();
    check("x0_instret", io_instret, 1);

    // Back-to-back EXU stream
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      set_exu(1, 5'(k), 1, 64'(k * 16), 64'h8000_0000 + 64'(k * 4));
      tick();
      check("b2b_commit", io_commit_valid, 1);
      check("b2b_waddr", io_RF_waddr, k);
    end
    io_EXU_valid = 0;
    tick();
    check("b2b_idle", io_commit_valid, 0);
    check("b2b_instret", io_instret, 4);

    // Reset arrives while the stage holds an instruction
    do_reset();
    set_exu(1, 5'd7, 1, 64'h77, 64'h8000_0100);
    tick();
    io_EXU_valid = 0;
    reset = 1'b0;
    #1;
    check("midrst_commit", io_commit_valid, 0);
    check("midrst_rf_wen", io_RF_wen, 0);
    tick();
    check("midrst_instret", io_instret, 0);
    check("midrst_commit_after", io_commit_valid, 0);
    reset = 1'b1;

    // Random traffic with occasional resets; producers hold until accepted
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      if (!io_EXU_valid || m_exu_fire) rand_exu();
      if (!io_LSU_valid || m_lsu_fire) rand_lsu();
      tick();
    end

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
